// File: rtl/hybrid_bpu_pkg.sv
// Shared types for the hybrid predictor chooser: FSM states and the in-flight
// queue entry, sized for the largest legal configuration.
package hybrid_bpu_pkg;
  localparam int PC_W      = 32;
  localparam int MAX_IDX_W = 16;
  localparam int MAX_PRED  = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } bpu_state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_PRED-1:0]  comp_dir;
    logic                 dir;
    logic [PC_W-1:0]      target;
    logic [PC_W-1:0]      pc;
  } bpu_entry_t;
endpackage

// File: rtl/hybrid_bpu_arbiter_if.sv
// Prediction request/response and resolution bundle for hybrid_bpu_arbiter.
interface hybrid_bpu_arbiter_if #(
  parameter int NUM_PRED = 2,
  parameter int IDX_W    = 10
);
  import hybrid_bpu_pkg::*;
  localparam int PICK_W = (NUM_PRED > 1) ? $clog2(NUM_PRED) : 1;

  logic                  pred_valid;
  logic                  pred_ready;
  logic [PC_W-1:0]       pred_pc;
  logic [IDX_W-1:0]      ghist_fold;
  logic [NUM_PRED-1:0]   comp_dir;
  logic [2*NUM_PRED-1:0] comp_conf;
  logic                  btb_hit;
  logic [PC_W-1:0]       btb_target;
  logic                  out_valid;
  logic                  out_dir;
  logic [PC_W-1:0]       out_target;
  logic [PICK_W-1:0]     out_pick;
  logic                  res_valid;
  logic                  res_dir;
  logic [PC_W-1:0]       res_target;
  logic                  redirect_valid;
  logic [PC_W-1:0]       redirect_pc;
  logic                  err_underflow;

  modport master (
    output pred_valid, pred_pc, ghist_fold, comp_dir, comp_conf, btb_hit, btb_target,
    output res_valid, res_dir, res_target,
    input  pred_ready, out_valid, out_dir, out_target, out_pick,
    input  redirect_valid, redirect_pc, err_underflow
  );

  modport slave (
    input  pred_valid, pred_pc, ghist_fold, comp_dir, comp_conf, btb_hit, btb_target,
    input  res_valid, res_dir, res_target,
    output pred_ready, out_valid, out_dir, out_target, out_pick,
    output redirect_valid, redirect_pc, err_underflow
  );
endinterface

// File: rtl/hybrid_bpu_arbiter_fifo.sv
// In-flight prediction queue: power-of-2 ring buffer with flush; a pop of an
// empty queue is ignored, a push while full only lands if a pop frees a slot.
module bpu_inflight_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/hybrid_bpu_arbiter.sv
// Hybrid predictor chooser: per-index saturating counters select a component
// direction; resolutions train them and redirect on mispredict.
// Build option HYBRID_CONF_OVERRIDE_EN forces pick 0 when component 0 is fully confident.
module hybrid_bpu_arbiter
  import hybrid_bpu_pkg::*;
#(
  parameter int NUM_PRED  = 2,
  parameter int CHOOSER_W = 3,
  parameter int IDX_W     = 10,
  parameter int DEPTH     = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  hybrid_bpu_arbiter_if.slave bus
);
  // state    | meaning
  // ST_INIT  | sweeping each chooser entry to the midpoint, requests blocked
  // ST_RUN   | accepting predictions and resolutions
  // ST_FLUSH | one-cycle recovery after a mispredict, queue already emptied

  localparam int PICK_W  = (NUM_PRED > 1) ? $clog2(NUM_PRED) : 1;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int ROW_W   = NUM_PRED * CHOOSER_W;
  localparam logic [CHOOSER_W-1:0] CTR_MID = CHOOSER_W'(1 << (CHOOSER_W - 1));

  bpu_state_e           state_q, state_d;
  logic [IDX_W-1:0]     init_ptr_q, init_ptr_d;
  logic [ROW_W-1:0]     tbl_q [ENTRIES];

  logic                 pred_ready, init_we, accept;
  logic [IDX_W-1:0]     pred_idx;
  logic [ROW_W-1:0]     pred_row;
  logic [PICK_W-1:0]    pick;
  logic [CHOOSER_W-1:0] best;
  logic                 pred_dir;
  logic [PC_W-1:0]      pred_target;

  bpu_entry_t           push_e, head;
  logic                 fifo_full, fifo_empty, do_pop, mispredict, disagree;
  logic [NUM_PRED-1:0]  head_dirs;
  logic [IDX_W-1:0]     upd_idx;
  logic [ROW_W-1:0]     upd_row;
  logic                 unused_bits;

  logic                 out_valid_q, out_dir_q, redirect_valid_q, err_q;
  logic [PC_W-1:0]      out_target_q, redirect_pc_q;
  logic [PICK_W-1:0]    out_pick_q;

  assign accept   = bus.pred_valid && pred_ready;
  assign pred_idx = bus.pred_pc[IDX_W+1:2] ^ bus.ghist_fold;
  assign pred_row = tbl_q[pred_idx];

  always_comb begin
    pick = '0;
    best = pred_row[CHOOSER_W-1:0];
    for (int k = 1; k < NUM_PRED; k++) begin
      if (pred_row[k*CHOOSER_W +: CHOOSER_W] > best) begin
        best = pred_row[k*CHOOSER_W +: CHOOSER_W];
        pick = PICK_W'(k);
      end
    end
`ifdef HYBRID_CONF_OVERRIDE_EN
    if (bus.comp_conf[1:0] == 2'b11) pick = '0;
`endif
  end

  assign pred_dir    = bus.comp_dir[pick];
  assign pred_target = (pred_dir && bus.btb_hit) ? bus.btb_target : bus.pred_pc + PC_W'(4);

  always_comb begin
    push_e          = '0;
    push_e.idx      = MAX_IDX_W'(pred_idx);
    push_e.comp_dir = MAX_PRED'(bus.comp_dir);
    push_e.dir      = pred_dir;
    push_e.target   = pred_target;
    push_e.pc       = bus.pred_pc;
  end

  // A mispredict flushes at the same edge, so a push in that cycle is dropped too.
  bpu_inflight_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (bpu_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (mispredict),
    .push_i      (accept),
    .push_data_i (push_e),
    .pop_i       (bus.res_valid),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign do_pop     = bus.res_valid && !fifo_empty;
  assign head_dirs  = head.comp_dir[NUM_PRED-1:0];
  assign upd_idx    = head.idx[IDX_W-1:0];
  assign disagree   = (head_dirs != '0) && (head_dirs != '1);
  assign mispredict = do_pop && ((head.dir != bus.res_dir) ||
                                 (bus.res_dir && (head.target != bus.res_target)));
  assign unused_bits = ^{head, bus.comp_conf};

  always_comb begin
    upd_row = tbl_q[upd_idx];
    for (int k = 0; k < NUM_PRED; k++) begin
      if (head_dirs[k] == bus.res_dir) begin
        if (upd_row[k*CHOOSER_W +: CHOOSER_W] != '1)
          upd_row[k*CHOOSER_W +: CHOOSER_W] = upd_row[k*CHOOSER_W +: CHOOSER_W] + 1'b1;
      end else if (upd_row[k*CHOOSER_W +: CHOOSER_W] != '0) begin
        upd_row[k*CHOOSER_W +: CHOOSER_W] = upd_row[k*CHOOSER_W +: CHOOSER_W] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN:   if (mispredict) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    pred_ready = (state_q == ST_RUN) && !fifo_full;
    init_we    = (state_q == ST_INIT);
  end

  // Queue is empty throughout INIT, so sweep and training writes never collide.
  always_ff @(posedge clk) begin
    if (init_we)
      tbl_q[init_ptr_q] <= {NUM_PRED{CTR_MID}};
    else if (do_pop && disagree)
      tbl_q[upd_idx] <= upd_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_dir_q        <= 1'b0;
      out_target_q     <= '0;
      out_pick_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      err_q            <= 1'b0;
    end else begin
      out_valid_q      <= accept && !mispredict;
      redirect_valid_q <= mispredict;
      if (accept) begin
        out_dir_q    <= pred_dir;
        out_target_q <= pred_target;
        out_pick_q   <= pick;
      end
      if (mispredict)
        redirect_pc_q <= bus.res_dir ? bus.res_target : head.pc + PC_W'(4);
      if (bus.res_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.pred_ready     = pred_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_dir        = out_dir_q;
  assign bus.out_target     = out_target_q;
  assign bus.out_pick       = out_pick_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.err_underflow  = err_q;
endmodule

// File: tb/tb_hybrid_bpu_arbiter.sv
// Bench for hybrid_bpu_arbiter: directed vectors and sequences plus random
// traffic, all checked against a transaction-level reference model.
module tb_hybrid_bpu_arbiter;
  import hybrid_bpu_pkg::*;

  localparam int NP      = 2;
  localparam int CW      = 3;
  localparam int IW      = 10;
  localparam int DEPTH   = 8;
  localparam int ENTRIES = 1 << IW;
  localparam int CMAX    = (1 << CW) - 1;
  localparam int CMID    = 1 << (CW - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hybrid_bpu_arbiter_if #(.NUM_PRED(NP), .IDX_W(IW)) bus ();

  hybrid_bpu_arbiter #(
    .NUM_PRED (NP),
    .CHOOSER_W(CW),
    .IDX_W    (IW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int            idx;
    logic [NP-1:0] cd;
    logic          dir;
    logic [31:0]   tgt;
    logic [31:0]   pc;
  } ment_t;

  typedef struct {
    logic [31:0]   pc;
    logic [IW-1:0] gh;
    logic [NP-1:0] cd;
    logic          hit;
    logic [31:0]   btgt;
    int            exp_pick;
    logic          exp_dir;
    logic [31:0]   exp_tgt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic            pv, hit, rv, rd, last_ready;
  logic [31:0]     ppc, btgt, rt;
  logic [IW-1:0]   gh;
  logic [NP-1:0]   cd;
  logic [2*NP-1:0] cc;

  int    m_ctr [ENTRIES][NP];
  ment_t m_q[$];
  int    m_init_left;
  logic  m_flush, m_err;
  logic  e_ov, e_dir, e_rv;
  logic [31:0] e_tgt, e_rpc;
  int    e_pick;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive();
    bus.pred_valid = pv;
    bus.pred_pc    = ppc;
    bus.ghist_fold = gh;
    bus.comp_dir   = cd;
    bus.comp_conf  = cc;
    bus.btb_hit    = hit;
    bus.btb_target = btgt;
    bus.res_valid  = rv;
    bus.res_dir    = rd;
    bus.res_target = rt;
  endtask

  // One clock: drive at the falling edge, predict the outcome from the model,
  // then check the registered outputs at the next falling edge.
  task automatic step();
    logic  m_ready, acc, misp, dir;
    logic [31:0] tgt;
    int    idx, pick, c;
    ment_t e;
    drive();
    #1;
    m_ready    = (m_init_left == 0) && !m_flush && (m_q.size() < DEPTH);
    last_ready = bus.pred_ready;
    chk("pred_ready", last_ready, m_ready);
    acc  = pv && m_ready;
    idx  = int'(ppc[IW+1:2] ^ gh);
    pick = 0;
    for (int k = 1; k < NP; k++)
      if (m_ctr[idx][k] > m_ctr[idx][pick]) pick = k;
`ifdef HYBRID_CONF_OVERRIDE_EN
    if (cc[1:0] == 2'b11) pick = 0;
`endif
    dir  = cd[pick];
    tgt  = (dir && hit) ? btgt : ppc + 32'd4;
    misp = 1'b0;
    if (rv) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        e    = m_q.pop_front();
        misp = (e.dir != rd) || (rd && (e.tgt != rt));
        if (e.cd != '0 && e.cd != {NP{1'b1}}) begin
          for (int k = 0; k < NP; k++) begin
            c = m_ctr[e.idx][k];
            m_ctr[e.idx][k] = (e.cd[k] == rd) ? ((c < CMAX) ? c + 1 : CMAX)
                                              : ((c > 0) ? c - 1 : 0);
          end
        end
        if (misp) e_rpc = rd ? rt : e.pc + 32'd4;
      end
    end
    if (acc && !misp) m_q.push_back('{idx, cd, dir, tgt, ppc});
    if (misp) m_q.delete();
    e_ov = acc && !misp;
    e_rv = misp;
    if (acc) begin
      e_dir  = dir;
      e_tgt  = tgt;
      e_pick = pick;
    end
    m_flush = misp;
    if (m_init_left > 0) m_init_left--;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", bus.out_valid, e_ov);
    if (e_ov) begin
      chk("out_dir", bus.out_dir, e_dir);
      chk("out_target", bus.out_target, e_tgt);
      chk("out_pick", bus.out_pick, e_pick);
    end
    chk("redirect_valid", bus.redirect_valid, e_rv);
    if (e_rv) chk("redirect_pc", bus.redirect_pc, e_rpc);
    chk("err_underflow", bus.err_underflow, m_err);
  endtask

  task automatic do_reset();
    pv = 0; rv = 0; rd = 0; rt = '0; ppc = '0; gh = '0; cd = '0; cc = '0; hit = 0; btgt = '0;
    drive();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pred_ready", bus.pred_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_dir", bus.out_dir, 1'b0);
    chk("rst_out_target", bus.out_target, 32'h0);
    chk("rst_out_pick", bus.out_pick, 32'h0);
    chk("rst_redirect_valid", bus.redirect_valid, 1'b0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst_err", bus.err_underflow, 1'b0);
    m_q.delete();
    for (int i = 0; i < ENTRIES; i++)
      for (int k = 0; k < NP; k++) m_ctr[i][k] = CMID;
    m_init_left = ENTRIES;
    m_flush = 1'b0;
    m_err   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_init();
    int zeros = 0;
    pv = 0; rv = 0;
    for (int n = 0; n < ENTRIES + 80; n++) begin
      step();
      if (last_ready) break;
      zeros++;
    end
    chk("init_len", zeros, ENTRIES);
  endtask

  task automatic set_res_correct();
    if (m_q.size() != 0) begin
      rd = m_q[0].dir;
      rt = m_q[0].tgt;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{32'h0000_0100, '0, 2'b10, 1'b0, 32'h0,         0, 1'b0, 32'h0000_0104};
    vecs[1] = '{32'h0000_0200, '0, 2'b01, 1'b1, 32'h0000_3000, 0, 1'b1, 32'h0000_3000};
    vecs[2] = '{32'h0000_0300, '0, 2'b01, 1'b0, 32'h0000_7000, 0, 1'b1, 32'h0000_0304};
    vecs[3] = '{32'h0000_0400, '0, 2'b10, 1'b1, 32'h0000_5000, 0, 1'b0, 32'h0000_0404};
    vecs[4] = '{32'hFFFF_FFFC, '0, 2'b11, 1'b0, 32'h0,         0, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h0000_1234, 10'h155, 2'b00, 1'b1, 32'h9000, 0, 1'b0, 32'h0000_1238};

    do_reset();
    run_init();

    // All counters at the midpoint: pick is always component 0.
    rv = 0; cc = '0;
    for (int i = 0; i < 6; i++) begin
      pv = 1; ppc = vecs[i].pc; gh = vecs[i].gh; cd = vecs[i].cd;
      hit = vecs[i].hit; btgt = vecs[i].btgt;
      step();
      chk("vec_valid", bus.out_valid, 1'b1);
      chk("vec_pick", bus.out_pick, vecs[i].exp_pick);
      chk("vec_dir", bus.out_dir, vecs[i].exp_dir);
      chk("vec_target", bus.out_target, vecs[i].exp_tgt);
    end
    pv = 0;
    step();

    // Reset with six entries in flight; they must be gone afterwards.
    do_reset();
    run_init();

    gh = '0; cd = 2'b10; hit = 0; btgt = '0; cc = '0;
    for (int r = 0; r < 4; r++) begin
      pv = 1; rv = 0; ppc = 32'h100; step();
      pv = 0; rv = 1; rd = 1; rt = 32'h104; step();
      rv = 0; step();
    end
    chk("train_ctr0", 32'(dut.tbl_q[64][2:0]), 32'd0);
    chk("train_ctr1", 32'(dut.tbl_q[64][5:3]), 32'd7);
    pv = 1; ppc = 32'h100; step();
    chk("train_pick", bus.out_pick, 32'd1);
    chk("train_dir", bus.out_dir, 1'b1);
    pv = 0; rv = 1; rd = 1; rt = 32'h104; step();
    rv = 0;
    chk("sat_ctr1", 32'(dut.tbl_q[64][5:3]), 32'd7);

    cd = 2'b00; hit = 0; pv = 1; rv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ppc = 32'h8000 + 32'(i * 4);
      step();
    end
    ppc = 32'h8100; rv = 1; set_res_correct(); step();
    chk("full_no_ready", last_ready, 1'b0);
    ppc = 32'h8104; set_res_correct(); step();
    chk("pushpop_ready", last_ready, 1'b1);
    ppc = 32'h8108; rv = 0; step();
    chk("pushpop_kept", last_ready, 1'b1);
    pv = 0; step();
    chk("refill_full", last_ready, 1'b0);
    for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++) begin
      rv = 1; set_res_correct(); step();
    end
    rv = 0;

    pv = 1; ppc = 32'h500; cd = 2'b00; hit = 0; step();
    ppc = 32'h600; rv = 1; rd = 1; rt = 32'h2000; step();
    chk("misp_redirect_valid", bus.redirect_valid, 1'b1);
    chk("misp_redirect_pc", bus.redirect_pc, 32'h2000);
    chk("misp_out_suppressed", bus.out_valid, 1'b0);
    rv = 0; step();
    chk("flush_not_ready", last_ready, 1'b0);
    pv = 0; rv = 1; step();
    chk("underflow_set", bus.err_underflow, 1'b1);
    rv = 0;
    repeat (3) step();
    chk("underflow_sticky", bus.err_underflow, 1'b1);

    do_reset();
    run_init();

    for (int n = 0; n < 3000; n++) begin
      pv   = 1'($urandom_range(0, 1));
      ppc  = 32'h1000 + 32'($urandom_range(0, 31) << 2);
      gh   = IW'($urandom_range(0, 3));
      cd   = NP'($urandom);
      cc   = (2*NP)'($urandom);
      hit  = 1'($urandom_range(0, 1));
      btgt = $urandom & 32'hFFFF_FFFC;
      if (m_q.size() != 0) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = m_q[0].dir;
        rt = m_q[0].tgt;
        if ($urandom_range(0, 9) == 0) rd = ~rd;
        if ($urandom_range(0, 9) == 0) rt = rt ^ 32'h40;
      end else begin
        rv = ($urandom_range(0, 40) == 0);
        rd = 1'($urandom_range(0, 1));
        rt = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
